// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a counter-qualified
// four-state filter that produces a clean level plus press/release strobes.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_clean,
    output logic       key_press,
    output logic       key_release,
    output logic       filtering,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_STABLE_HI = 2'd0;
    localparam logic [1:0] ST_FILT_LO   = 2'd1;
    localparam logic [1:0] ST_STABLE_LO = 2'd2;
    localparam logic [1:0] ST_FILT_HI   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_press;
    logic             r_release;
    logic             r_filtering;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clean_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_filtering_nxt;

    // Pad is asynchronous; only r_s2 is ever consumed by the filter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_clean_nxt   = r_clean;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_STABLE_HI: begin
                w_cnt_nxt = CNT_ZERO;
                if (!r_s2) begin
                    w_state_nxt = ST_FILT_LO;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_FILT_LO: begin
                if (r_s2) begin
                    w_state_nxt = ST_STABLE_HI;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_STABLE_LO;
                    w_cnt_nxt   = CNT_ZERO;
                    w_clean_nxt = 1'b0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STABLE_LO: begin
                w_cnt_nxt = CNT_ZERO;
                if (r_s2) begin
                    w_state_nxt = ST_FILT_HI;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_FILT_HI: begin
                if (!r_s2) begin
                    w_state_nxt = ST_STABLE_LO;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_STABLE_HI;
                    w_cnt_nxt     = CNT_ZERO;
                    w_clean_nxt   = 1'b1;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE_HI;
                w_cnt_nxt   = CNT_ZERO;
                w_clean_nxt = 1'b1;
            end
        endcase
        // Registered copy of the state decode keeps filtering glitch-free.
        w_filtering_nxt = (w_state_nxt == ST_FILT_LO) || (w_state_nxt == ST_FILT_HI);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_STABLE_HI;
            r_cnt       <= CNT_ZERO;
            r_clean     <= 1'b1;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_filtering <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_clean     <= w_clean_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_filtering <= w_filtering_nxt;
        end
    end

    assign key_clean   = r_clean;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign filtering   = r_filtering;
    assign dbg_state   = r_state;

endmodule
